matrix_scan_tx: RTL and testbench

Host-side scan driver for the badge LED matrix. It holds a 16×16 frame buffer and, for each column, serialises the 16-bit row word MSB-first onto `row_clk`/`row_data` for the CPLD's row shift register. It then drives the 4-bit column index that the CPLD decodes to a one-hot column enable, and holds the column lit for a fixed dwell. It also receives the CPLD's 3-bit encoded button code, synchronises it, optionally debounces it, and reports new presses.

---
 rtl/matrix_pkg.sv | 26 ++
 rtl/button_sync.sv | 85 ++++++++
 rtl/matrix_scan_tx.sv | 152 +++++++++++++++
 tb/tb_matrix_scan_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the badge LED matrix scan driver.
// Optional button debounce is selected with the MATRIX_BTN_DEBOUNCE_EN macro.
package matrix_pkg;

    localparam int MATRIX_ROWS = 16;
    localparam int MATRIX_COLS = 16;
    localparam int BTN_W       = 3;
    localparam int COL_W       = $clog2(MATRIX_COLS);
    localparam int BIT_W       = $clog2(MATRIX_ROWS);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_DWELL    = 3'd5
    } scan_state_t;

    typedef logic [MATRIX_ROWS-1:0] row_word_t;

    function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] col);
        return col + 4'd1;
    endfunction

endpackage

// File: rtl/button_sync.sv
// CPLD button code synchroniser with optional debounce (MATRIX_BTN_DEBOUNCE_EN)
// and new-press event detection.
module button_sync
    import matrix_pkg::*;
#(
    parameter int DEBOUNCE = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BTN_W-1:0] code,
    output logic [BTN_W-1:0] button,
    output logic             button_event
);

    logic [BTN_W-1:0] sync1_r;
    logic [BTN_W-1:0] sync2_r;
    logic [BTN_W-1:0] button_r;
    logic             event_r;
    logic             accept_s;
    logic [BTN_W-1:0] accept_code_s;

    // Two-flop synchroniser for the asynchronous CPLD code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'd0;
            sync2_r <= 3'd0;
        end else begin
            sync1_r <= code;
            sync2_r <= sync1_r;
        end
    end

`ifdef MATRIX_BTN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [BTN_W-1:0] cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_full_s;

    // Restart the stability count whenever the synchronised code moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= 3'd0;
            cnt_r  <= '0;
        end else if (sync2_r != cand_r) begin
            cand_r <= sync2_r;
            cnt_r  <= '0;
        end else if (!cnt_full_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Accept the candidate once it has been stable long enough
    always_comb begin
        cnt_full_s    = (cnt_r == CNT_W'(DEBOUNCE - 1));
        accept_s      = (sync2_r == cand_r) && cnt_full_s;
        accept_code_s = cand_r;
    end
`else
    // Without debounce the synchroniser output is taken every cycle
    always_comb begin
        accept_s      = 1'b1;
        accept_code_s = sync2_r;
    end
`endif

    // Accepted code and one-cycle pulse on a change to a nonzero code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button_r <= 3'd0;
            event_r  <= 1'b0;
        end else if (accept_s) begin
            button_r <= accept_code_s;
            event_r  <= (accept_code_s != button_r) && (accept_code_s != 3'd0);
        end else begin
            event_r  <= 1'b0;
        end
    end

    assign button       = button_r;
    assign button_event = event_r;

endmodule

// File: rtl/matrix_scan_tx.sv
// Host-side LED matrix scan driver: frame buffer, serial row shifter, column
// dwell sequencer and button receiver (debounce via MATRIX_BTN_DEBOUNCE_EN).
module matrix_scan_tx
    import matrix_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int DWELL    = 256,
    parameter int DEBOUNCE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [3:0]  wr_col,
    input  logic [15:0] wr_data,
    output logic        row_clk,
    output logic        row_data,
    output logic [3:0]  column,
    output logic        blank,
    output logic        frame_start,
    input  logic [2:0]  button_code,
    output logic [2:0]  button,
    output logic        button_event
);

    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int DWELL_W = $clog2(DWELL + 1);

    scan_state_t        state_r, state_s;
    row_word_t          fb_r [MATRIX_COLS];
    row_word_t          shreg_r;
    logic [COL_W-1:0]   col_r, col_s;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [DWELL_W-1:0] dwell_cnt_r;
    logic               row_clk_r, blank_r, frame_start_r;
    logic [COL_W-1:0]   column_r;
    logic               div_done_s, dwell_done_s, last_bit_s, shifting_s;

    // Next-state and next-column decode
    always_comb begin
        state_s      = state_r;
        col_s        = col_r;
        shifting_s   = (state_r == ST_SHIFT_LO) || (state_r == ST_SHIFT_HI);
        div_done_s   = (div_cnt_r == DIV_W'(CLK_DIV - 1));
        dwell_done_s = (dwell_cnt_r == DWELL_W'(DWELL - 1));
        last_bit_s   = (bit_cnt_r == 4'd15);
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_LOAD;
                    col_s   = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD:     state_s = ST_SHIFT_LO;
            ST_SHIFT_LO: begin
                if (div_done_s) state_s = ST_SHIFT_HI;
                else            state_s = ST_SHIFT_LO;
            end
            ST_SHIFT_HI: begin
                if (div_done_s) state_s = last_bit_s ? ST_LATCH : ST_SHIFT_LO;
                else            state_s = ST_SHIFT_HI;
            end
            ST_LATCH:    state_s = ST_DWELL;
            ST_DWELL: begin
                if (dwell_done_s) begin
                    col_s   = col_inc(col_r);
                    state_s = enable ? ST_LOAD : ST_IDLE;
                end else begin
                    state_s = ST_DWELL;
                end
            end
            default:     state_s = ST_IDLE;
        endcase
    end

    // Sequencer state, timing counters and the row shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            col_r       <= 4'd0;
            div_cnt_r   <= '0;
            dwell_cnt_r <= '0;
            bit_cnt_r   <= 4'd0;
            shreg_r     <= 16'h0000;
        end else begin
            state_r     <= state_s;
            col_r       <= col_s;
            div_cnt_r   <= (shifting_s && !div_done_s) ? div_cnt_r + DIV_W'(1) : '0;
            dwell_cnt_r <= (state_r == ST_DWELL && !dwell_done_s) ?
                           dwell_cnt_r + DWELL_W'(1) : '0;
            case (state_r)
                ST_LOAD: begin
                    shreg_r   <= fb_r[col_r];
                    bit_cnt_r <= 4'd0;
                end
                ST_SHIFT_HI: begin
                    // Clearing after the last bit parks row_data low for LATCH
                    if (div_done_s) begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        shreg_r   <= last_bit_s ? 16'h0000 :
                                     {shreg_r[MATRIX_ROWS-2:0], 1'b0};
                    end
                end
                default: begin
                    shreg_r <= shreg_r;
                end
            endcase
        end
    end

    // Output registers, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_clk_r     <= 1'b0;
            blank_r       <= 1'b1;
            frame_start_r <= 1'b0;
            column_r      <= 4'd0;
        end else begin
            row_clk_r     <= (state_s == ST_SHIFT_HI);
            blank_r       <= (state_s != ST_DWELL);
            frame_start_r <= (state_s == ST_LOAD) && (col_s == 4'd0);
            if (state_s == ST_LATCH) column_r <= col_r;
        end
    end

    // Frame buffer; a write in the LOAD cycle lands after LOAD has read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MATRIX_COLS; i++) fb_r[i] <= 16'h0000;
        end else if (wr_en) begin
            fb_r[wr_col] <= wr_data;
        end
    end

    assign row_clk     = row_clk_r;
    assign row_data    = shreg_r[MATRIX_ROWS-1];
    assign column      = column_r;
    assign blank       = blank_r;
    assign frame_start = frame_start_r;

    button_sync #(.DEBOUNCE(DEBOUNCE)) u_button_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .code         (button_code),
        .button       (button),
        .button_event (button_event)
    );

endmodule

// File: tb/tb_matrix_scan_tx.sv
// Directed/randomised bench for matrix_scan_tx with a CPLD row-register model
// and a cycle-position timing model derived from the column timing formula.
module tb_matrix_scan_tx;

    localparam int CLK_DIV   = 4;
    localparam int DWELL     = 256;
    localparam int DEBOUNCE  = 8;
    localparam int LATCH_OFF = 1 + 32 * CLK_DIV;
    localparam int COL_CYC   = LATCH_OFF + 1 + DWELL;
    localparam int FRAME     = 16 * COL_CYC;
`ifdef MATRIX_BTN_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, enable, wr_en;
    logic [3:0]  wr_col;
    logic [15:0] wr_data;
    logic        row_clk, row_data, blank, frame_start, button_event;
    logic [3:0]  column;
    logic [2:0]  button_code, button;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] fb_m [16];
    logic [15:0] cpld_row = 16'h0000;
    int          cpld_cnt = 0;

    matrix_scan_tx #(.CLK_DIV(CLK_DIV), .DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut (
        .clk (clk), .rst_n (rst_n), .enable (enable), .wr_en (wr_en),
        .wr_col (wr_col), .wr_data (wr_data), .row_clk (row_clk),
        .row_data (row_data), .column (column), .blank (blank),
        .frame_start (frame_start), .button_code (button_code),
        .button (button), .button_event (button_event)
    );

    always #5 clk = ~clk;

    // CPLD row shift register: samples row_data on rising row_clk
    always @(posedge row_clk) begin
        cpld_row <= {cpld_row[14:0], row_data};
        cpld_cnt <= cpld_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt0, rc_err, blank_err, fs_err, cb_err, fs_cnt, fs_first, fs_second;
        int prev_col, prev_blank, got, idle_k, kend;
        logic [15:0] v9;

        rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_col = 4'd0;
        wr_data = 16'h0000; button_code = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_row_clk", row_clk, 0);
        check("rst_row_data", row_data, 0);
        check("rst_column", column, 0);
        check("rst_blank", blank, 1);
        check("rst_frame_start", frame_start, 0);
        check("rst_button", button, 0);
        check("rst_button_event", button_event, 0);
        rst_n = 1'b1;

        // Load the frame buffer: column 0 fixed pattern, walking ones, random
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            fb_m[c] = (c == 0) ? 16'hA5C3 : (c < 8) ? (16'h0001 << c) : 16'($urandom);
            wr_en = 1'b1; wr_col = 4'(c); wr_data = fb_m[c];
        end
        @(negedge clk);
        wr_en = 1'b0;
        enable = 1'b1;

        got = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin got = i; break; end
        end
        check("first_load_latency", got, 1);

        // Two full frames plus a partial third frame stopped at column 3
        idle_k = 2 * FRAME + 4 * COL_CYC;
        kend   = idle_k + 30;
        rc_err = 0; blank_err = 0; fs_err = 0; cb_err = 0; fs_cnt = 0;
        fs_first = -1; fs_second = -1; cnt0 = cpld_cnt; v9 = 16'h0000;
        prev_col = column; prev_blank = blank;
        for (int k = 0; k <= kend; k++) begin
            int off, c, exp_rc, exp_blank, exp_fs;
            if (k > 0) @(negedge clk);
            off = k % COL_CYC;
            c   = (k / COL_CYC) % 16;
            if (k < idle_k) begin
                exp_rc    = (off >= 1 && off <= 32 * CLK_DIV) ? ((off - 1) / CLK_DIV) % 2 : 0;
                exp_blank = (off > LATCH_OFF) ? 0 : 1;
                exp_fs    = (off == 0 && c == 0) ? 1 : 0;
            end else begin
                exp_rc = 0; exp_blank = 1; exp_fs = 0;
            end
            if (row_clk !== 1'(exp_rc)) rc_err++;
            if (blank !== 1'(exp_blank)) blank_err++;
            if (frame_start !== 1'(exp_fs)) fs_err++;
            if (column !== 4'(prev_col) && (blank !== 1'b1 || prev_blank != 1)) cb_err++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
            prev_col = column; prev_blank = blank;
            if (k < idle_k && off == 0) cnt0 = cpld_cnt;
            if (k < idle_k && off == LATCH_OFF) begin
                check("latch_row_word", cpld_row, fb_m[c]);
                check("latch_bit_count", cpld_cnt - cnt0, 16);
                check("latch_column", column, c);
            end
            if (k == LATCH_OFF + 1) check("col0_blank_fall", blank, 0);
            // Stimulus actions
            if (k == 2 * COL_CYC) begin
                wr_en = 1'b1; wr_col = 4'd2; wr_data = 16'hFFFF;
            end else if (k == 5 * COL_CYC + 50) begin
                v9 = 16'($urandom);
                wr_en = 1'b1; wr_col = 4'd9; wr_data = v9; fb_m[9] = v9;
            end else begin
                wr_en = 1'b0;
            end
            if (k == 3 * COL_CYC) fb_m[2] = 16'hFFFF;
            if (k == 2 * FRAME + 3 * COL_CYC + 1 + 8 * CLK_DIV + 2) enable = 1'b0;
        end
        check("row_clk_timing", rc_err, 0);
        check("blank_timing", blank_err, 0);
        check("frame_start_timing", fs_err, 0);
        check("column_change_while_lit", cb_err, 0);
        check("frame_start_count", fs_cnt, 3);
        check("frame_interval", fs_second - fs_first, FRAME);
        check("idle_column", column, 3);
        check("idle_row_data", row_data, 0);

        // Asynchronous reset in the middle of SHIFT_HI
        enable = 1'b1;
        @(negedge clk);
        check("restart_frame_start", frame_start, 1);
        repeat (CLK_DIV + 1) @(negedge clk);
        check("pre_reset_row_clk", row_clk, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_row_clk", row_clk, 0);
        check("async_rst_row_data", row_data, 0);
        check("async_rst_column", column, 0);
        check("async_rst_blank", blank, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) fb_m[c] = 16'h0000;
        @(negedge clk);
        check("post_reset_frame_start", frame_start, 1);
        cnt0 = cpld_cnt;
        repeat (LATCH_OFF) @(negedge clk);
        check("post_reset_row_word", cpld_row, fb_m[0]);
        check("post_reset_bit_count", cpld_cnt - cnt0, 16);
        check("post_reset_column", column, 0);
        @(negedge clk);
        check("post_reset_blank_fall", blank, 0);
        enable = 1'b0;

        // Button receiver: short glitch, long press, then random presses
        for (int t = 0; t < 4; t++) begin
            logic [2:0] code, btn_at_ev;
            int hold, ev_n, lat, exp_ev;
            code = (t < 2) ? 3'b101 : 3'($urandom_range(1, 7));
            hold = (t == 0) ? 5 : (t == 1) ? 20 : $urandom_range(1, 20);
            if (hold == DEBOUNCE) hold = DEBOUNCE + 3;
            ev_n = 0; lat = 0; btn_at_ev = 3'd0;
            @(negedge clk);
            button_code = code;
            for (int i = 1; i <= hold + 16; i++) begin
                @(negedge clk);
                if (i == hold) button_code = 3'd0;
                if (button_event === 1'b1) begin
                    ev_n++;
                    if (lat == 0) begin lat = i; btn_at_ev = button; end
                end
            end
            exp_ev = DEB_ON ? ((hold > DEBOUNCE) ? 1 : 0) : 1;
            check("btn_event_count", ev_n, exp_ev);
            check("btn_event_latency", lat, exp_ev ? (DEB_ON ? DEBOUNCE + 3 : 3) : 0);
            check("btn_code_at_event", btn_at_ev, exp_ev ? code : 3'd0);
            check("btn_released", button, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
